a51_lfsr_core: RTL and testbench
================================

Name: a51_lfsr_core

Overview:
- Datapath downstream of the A5/1 stage counter: consumes its STAGEONE/STAGETWO/STAGETHREE/OUTPUTSTAGE/DONE flags and ENABLE.
- Holds the three A5/1 LFSRs and performs the cipher phases in order: key load (64 bits), frame load (22 bits), 100-cycle mixing with keystream discarded, then keystream output.
- In the output phase, XORs serial plaintext DIN with keystream to produce DOUT/DVALID for the serial output logic.

Parameters:
- KEY_BITS, 64, number of key bits loaded.
- FRAME_BITS, 22, number of frame bits loaded.
- MIX_CYCLES, 100, majority-clocked cycles with keystream discarded.
- OUT_BITS, 128, maximum keystream bits emitted.

Ports:
- C  input  1  clock; all state updates on posedge.
- CLR  input  1  reset; asynchronous, active-high.
- ENABLE  input  1  advance enable; same signal that drives the stage counter.
- STAGEONE  input  1  key-load phase flag.
- STAGETWO  input  1  frame-load phase flag.
- STAGETHREE  input  1  mixing phase flag.
- OUTPUTSTAGE  input  1  keystream phase flag.
- DONE  input  1  finished flag.
- KEY  input  64  session key; bit i loaded on the i-th load cycle; held stable throughout.
- FRAME  input  22  frame number; bit i loaded on the i-th frame cycle.
- DIN  input  1  plaintext/ciphertext bit.
- DOUT  output  1  DIN XOR keystream (registered).
- DVALID  output  1  DOUT valid strobe (registered).
- KS  output  1  current keystream bit, R1[18]^R2[21]^R3[22] (combinational from registers).
- OCNT  output  8  count of bits emitted.

Behaviour:
- Registers:
  - R1[18:0]: taps 13,16,17,18; clock bit 8.
  - R2[21:0]: taps 20,21; clock bit 10.
  - R3[22:0]: taps 7,20,21,22; clock bit 10.
- Shift rule: Rn <= {Rn[len-2:0], fb}, where fb = XOR of the register's taps (XOR load bit during load phases).
- Internal counters: kidx 0..64, fidx 0..22, midx 0..100, OCNT 0..128. Each saturates at its parameter value.
- Reset (CLR=1, asynchronous, any time including mid-operation): R1=R2=R3=0, all counters 0, DOUT=0, DVALID=0. Priority over everything.
- ENABLE=0: all state held; DVALID<=0.
- Flag priority when several are high: STAGEONE > STAGETWO > STAGETHREE > OUTPUTSTAGE > DONE.
- Per enabled posedge, by phase:
  - Key load (STAGEONE): if kidx<64, all three registers clock with fb ^= KEY[kidx], then kidx++. If kidx==64 (the counter's extra 65th stage-one cycle), nothing changes.
  - Frame load (STAGETWO): same as key load with FRAME[fidx]; saturates at 22.
  - Mix (STAGETHREE): if midx<100, compute maj = majority(R1[8],R2[10],R3[10]). Clock only the registers whose clock bit equals maj; no key/frame XOR; midx++. Otherwise hold. DVALID<=0.
  - Output (OUTPUTSTAGE): if OCNT<128, majority-clock as in mix, then DOUT <= DIN ^ (keystream from the post-clock register values); DVALID<=1; OCNT++. If OCNT==128, DVALID<=0 and registers hold.
  - DONE: all hold; DVALID<=0.
  - No flag high: hold; DVALID<=0.
- Latency: DIN sampled at output edge k appears on DOUT after edge k, with DVALID high for that cycle.
- DVALID is 0 in all non-output cycles.
- KEY/FRAME changes mid-load are undefined usage; the block does not latch them.

Test Plan:
- Assert CLR asynchronously mid-mixing, with no clock edge -> R1/R2/R3, OCNT, DOUT, DVALID read 0 immediately.
- KEY=64'h1, one enabled STAGEONE cycle -> R1=19'h1, R2=22'h1, R3=23'h1. A second cycle -> each register = 2. 65 STAGEONE cycles -> kidx stops at 64; the 65th cycle leaves registers unchanged.
- KEY=0, FRAME=0, full sequence -> registers stay 0, KS=0, DOUT==DIN for all 128 DVALID pulses, OCNT ends at 128.
- KEY bytes 12 23 45 67 89 AB CD EF (bit i = bit i%8 of byte i/8), FRAME=22'h134, DIN=0 -> first 114 DOUT bits, packed MSB-first, = 53 4E AA 58 2F E8 15 1A B6 E1 85 5A 72 8C 00 (last byte partial).
- ENABLE deasserted for 5 cycles during OUTPUTSTAGE -> DVALID=0, OCNT and registers frozen. Resumed stream is identical to an uninterrupted run.
- STAGETWO and STAGETHREE both high -> frame-load behaviour only; DONE high -> no register change, DVALID=0.

Source files
------------

// File: rtl/a51_lfsr_core.sv
// A5/1 keystream datapath: three LFSRs driven through key load, frame load,
// majority-clocked mixing and keystream output by external stage-counter flags.
module a51_lfsr_core #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22,
  parameter int MIX_CYCLES = 100,
  parameter int OUT_BITS   = 128
) (
  input  logic                  C,
  input  logic                  CLR,
  input  logic                  ENABLE,
  input  logic                  STAGEONE,
  input  logic                  STAGETWO,
  input  logic                  STAGETHREE,
  input  logic                  OUTPUTSTAGE,
  input  logic                  DONE,
  input  logic [KEY_BITS-1:0]   KEY,
  input  logic [FRAME_BITS-1:0] FRAME,
  input  logic                  DIN,
  output logic                  DOUT,
  output logic                  DVALID,
  output logic                  KS,
  output logic [7:0]            OCNT
);

  localparam int KCW = $clog2(KEY_BITS + 1);
  localparam int KIW = $clog2(KEY_BITS);
  localparam int FCW = $clog2(FRAME_BITS + 1);
  localparam int FIW = $clog2(FRAME_BITS);
  localparam int MCW = $clog2(MIX_CYCLES + 1);

  typedef enum logic [2:0] {
    PH_IDLE, PH_KEY, PH_FRAME, PH_MIX, PH_OUT, PH_DONE
  } phase_t;

  phase_t         phase;
  logic [18:0]    r1, r1_ld, r1_mj;
  logic [21:0]    r2, r2_ld, r2_mj;
  logic [22:0]    r3, r3_ld, r3_mj;
  logic [KCW-1:0] kidx;
  logic [FCW-1:0] fidx;
  logic [MCW-1:0] midx;
  logic           fb1, fb2, fb3, maj, ld_bit, ks_next;
  logic           key_more, frame_more, mix_more, out_more;

  // Several flags may overlap at stage boundaries; the earliest phase wins.
  always_comb begin
    phase = PH_IDLE;
    if (STAGEONE)         phase = PH_KEY;
    else if (STAGETWO)    phase = PH_FRAME;
    else if (STAGETHREE)  phase = PH_MIX;
    else if (OUTPUTSTAGE) phase = PH_OUT;
    else if (DONE)        phase = PH_DONE;
  end

  assign key_more   = kidx < KCW'(KEY_BITS);
  assign frame_more = fidx < FCW'(FRAME_BITS);
  assign mix_more   = midx < MCW'(MIX_CYCLES);
  assign out_more   = OCNT < 8'(OUT_BITS);

  always_comb begin
    fb1 = r1[13] ^ r1[16] ^ r1[17] ^ r1[18];
    fb2 = r2[20] ^ r2[21];
    fb3 = r3[7] ^ r3[20] ^ r3[21] ^ r3[22];

    ld_bit = 1'b0;
    if (phase == PH_KEY)        ld_bit = KEY[kidx[KIW-1:0]];
    else if (phase == PH_FRAME) ld_bit = FRAME[fidx[FIW-1:0]];

    r1_ld = {r1[17:0], fb1 ^ ld_bit};
    r2_ld = {r2[20:0], fb2 ^ ld_bit};
    r3_ld = {r3[21:0], fb3 ^ ld_bit};

    // Only registers whose clock bit agrees with the majority advance.
    maj   = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    r1_mj = (r1[8]  == maj) ? {r1[17:0], fb1} : r1;
    r2_mj = (r2[10] == maj) ? {r2[20:0], fb2} : r2;
    r3_mj = (r3[10] == maj) ? {r3[21:0], fb3} : r3;

    ks_next = r1_mj[18] ^ r2_mj[21] ^ r3_mj[22];
  end

  assign KS = r1[18] ^ r2[21] ^ r3[22];

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r1     <= '0;
      r2     <= '0;
      r3     <= '0;
      kidx   <= '0;
      fidx   <= '0;
      midx   <= '0;
      OCNT   <= '0;
      DOUT   <= 1'b0;
      DVALID <= 1'b0;
    end else begin
      DVALID <= 1'b0;
      if (ENABLE) begin
        case (phase)
          PH_KEY: if (key_more) begin
            r1   <= r1_ld;
            r2   <= r2_ld;
            r3   <= r3_ld;
            kidx <= kidx + KCW'(1);
          end
          PH_FRAME: if (frame_more) begin
            r1   <= r1_ld;
            r2   <= r2_ld;
            r3   <= r3_ld;
            fidx <= fidx + FCW'(1);
          end
          PH_MIX: if (mix_more) begin
            r1   <= r1_mj;
            r2   <= r2_mj;
            r3   <= r3_mj;
            midx <= midx + MCW'(1);
          end
          // Keystream comes from the post-clock state, hence ks_next.
          PH_OUT: if (out_more) begin
            r1     <= r1_mj;
            r2     <= r2_mj;
            r3     <= r3_mj;
            DOUT   <= DIN ^ ks_next;
            DVALID <= 1'b1;
            OCNT   <= OCNT + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a51_lfsr_core.sv
// Scoreboarded bench for a51_lfsr_core: stimulus queues expected DOUT bits,
// a negedge monitor pops one per DVALID pulse.
module tb_a51_lfsr_core;

  logic        C = 1'b0;
  logic        CLR, ENABLE, STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE;
  logic [63:0] KEY;
  logic [21:0] FRAME;
  logic        DIN;
  logic        DOUT, DVALID, KS;
  logic [7:0]  OCNT;

  localparam logic [4:0] F_NONE = 5'b00000, F_KEY = 5'b10000, F_FRM = 5'b01000,
                         F_MIX = 5'b00100, F_OUT = 5'b00010, F_DONE = 5'b00001;

  a51_lfsr_core dut (
    .C(C), .CLR(CLR), .ENABLE(ENABLE), .STAGEONE(STAGEONE), .STAGETWO(STAGETWO),
    .STAGETHREE(STAGETHREE), .OUTPUTSTAGE(OUTPUTSTAGE), .DONE(DONE),
    .KEY(KEY), .FRAME(FRAME), .DIN(DIN), .DOUT(DOUT), .DVALID(DVALID),
    .KS(KS), .OCNT(OCNT)
  );

  always #5 C = ~C;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  bit exp_q[$];
  bit mon_e;

  always @(negedge C) begin
    if (DVALID === 1'b1) begin
      tests++;
      pops++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dvalid_unexpected: dout=%0b with no expected bit queued", DOUT);
      end else begin
        mon_e = exp_q.pop_front();
        if (DOUT !== mon_e) begin
          fails++;
          $display("FAIL dout_bit%0d: got %0b expected %0b", pops - 1, DOUT, mon_e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE} = f;
  endtask

  task automatic run(input logic [4:0] f, input int n);
    set_flags(f);
    repeat (n) tick();
  endtask

  task automatic clear_pulse();
    set_flags(F_NONE);
    CLR = 1'b1;
    #2;
    CLR = 1'b0;
  endtask

  task automatic load_all(input logic [63:0] k, input logic [21:0] f);
    KEY = k;
    FRAME = f;
    run(F_KEY, 65);
    run(F_FRM, 22);
    run(F_MIX, 100);
  endtask

  task automatic out_bit(input bit din, input bit ks);
    DIN = din;
    set_flags(F_OUT);
    exp_q.push_back(din ^ ks);
    tick();
  endtask

  logic [127:0] zpat;
  logic [119:0] ref_ks;
  logic [18:0]  s1;
  logic [21:0]  s2;
  logic [22:0]  s3;

  initial begin
    zpat   = 128'h8F3A_6C21_D5E0_4B97_1E2D_3C4B_5A69_7887;
    ref_ks = 120'h534E_AA58_2FE8_151A_B6E1_855A_728C_00;
    CLR = 1'b1; ENABLE = 1'b0; KEY = '0; FRAME = '0; DIN = 1'b0;
    set_flags(F_NONE);

    // Reset state
    tick();
    check("rst_r1", 32'(dut.r1), 0);
    check("rst_r2", 32'(dut.r2), 0);
    check("rst_r3", 32'(dut.r3), 0);
    check("rst_ocnt", 32'(OCNT), 0);
    check("rst_dout", 32'(DOUT), 0);
    check("rst_dvalid", 32'(DVALID), 0);
    CLR = 1'b0;
    ENABLE = 1'b1;

    // Key load with KEY=1, then saturation at 64
    KEY = 64'h1;
    run(F_KEY, 1);
    check("key1_r1", 32'(dut.r1), 1);
    check("key1_r2", 32'(dut.r2), 1);
    check("key1_r3", 32'(dut.r3), 1);
    run(F_KEY, 1);
    check("key2_r1", 32'(dut.r1), 2);
    check("key2_r2", 32'(dut.r2), 2);
    check("key2_r3", 32'(dut.r3), 2);
    run(F_KEY, 62);
    check("kidx_64", 32'(dut.kidx), 64);
    s1 = dut.r1; s2 = dut.r2; s3 = dut.r3;
    run(F_KEY, 1);
    check("key65_r1_hold", 32'(dut.r1), 32'(s1));
    check("key65_r2_hold", 32'(dut.r2), 32'(s2));
    check("key65_r3_hold", 32'(dut.r3), 32'(s3));
    check("kidx_sat", 32'(dut.kidx), 64);

    // All-zero key/frame: keystream is 0, DOUT tracks DIN
    clear_pulse();
    pops = 0;
    load_all(64'h0, 22'h0);
    for (int i = 0; i < 128; i++) out_bit(zpat[i], 1'b0);
    check("zero_ks", 32'(KS), 0);
    run(F_OUT, 3);
    check("zero_ocnt_sat", 32'(OCNT), 128);
    check("zero_dvalid_sat", 32'(DVALID), 0);
    check("zero_pops", 32'(pops), 128);
    check("zero_q_empty", 32'(exp_q.size()), 0);
    // Async clear with no clock edge
    set_flags(F_MIX);
    CLR = 1'b1;
    #1;
    check("aclr_ocnt", 32'(OCNT), 0);
    check("aclr_dout", 32'(DOUT), 0);
    #1;
    CLR = 1'b0;

    // Async clear mid-mixing with live register contents
    load_all(64'hEFCD_AB89_6745_2312, 22'h134);
    clear_pulse();
    load_all(64'hEFCD_AB89_6745_2312, 22'h134);
    run(F_NONE, 1);
    clear_pulse();
    KEY = 64'hEFCD_AB89_6745_2312;
    run(F_KEY, 65);
    run(F_FRM, 22);
    run(F_MIX, 50);
    CLR = 1'b1;
    #1;
    check("mixclr_r1", 32'(dut.r1), 0);
    check("mixclr_r2", 32'(dut.r2), 0);
    check("mixclr_r3", 32'(dut.r3), 0);
    check("mixclr_midx", 32'(dut.midx), 0);
    check("mixclr_dvalid", 32'(DVALID), 0);
    #1;
    CLR = 1'b0;
    set_flags(F_NONE);

    // Reference vector with a 5-cycle ENABLE gap at bit 40
    pops = 0;
    load_all(64'hEFCD_AB89_6745_2312, 22'h134);
    for (int i = 0; i < 114; i++) begin
      if (i == 40) begin
        ENABLE = 1'b0;
        s1 = dut.r1;
        for (int j = 0; j < 5; j++) begin
          tick();
          check("gap_dvalid", 32'(DVALID), 0);
        end
        check("gap_ocnt", 32'(OCNT), 40);
        check("gap_r1_frozen", 32'(dut.r1), 32'(s1));
        ENABLE = 1'b1;
      end
      out_bit(1'b0, ref_ks[119-i]);
    end
    run(F_NONE, 1);
    check("ref_ocnt", 32'(OCNT), 114);
    check("ref_pops", 32'(pops), 114);
    check("ref_q_empty", 32'(exp_q.size()), 0);
    check("ref_dvalid_idle", 32'(DVALID), 0);

    // Overlapping flags: frame load wins; DONE holds everything
    clear_pulse();
    FRAME = 22'h1;
    run(F_FRM | F_MIX, 1);
    check("prio_r1", 32'(dut.r1), 1);
    check("prio_r2", 32'(dut.r2), 1);
    check("prio_r3", 32'(dut.r3), 1);
    check("prio_dvalid", 32'(DVALID), 0);
    run(F_DONE, 3);
    check("done_r1", 32'(dut.r1), 1);
    check("done_r3", 32'(dut.r3), 1);
    check("done_dvalid", 32'(DVALID), 0);
    check("done_ocnt", 32'(OCNT), 0);
    set_flags(F_NONE);
    tick();

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL final_q: got %0d leftover expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
